// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall-vector
// bit indices, multiply FSM encodings and register/load-opcode constants.
package pipe_ctrl_pkg;

  localparam int STALL_W     = 5;
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;

  typedef enum logic [1:0] {
    PCTRL_IDLE = 2'd0,
    PCTRL_MUL  = 2'd1,
    PCTRL_DONE = 2'd2
  } pctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load opcodes EX decodes into i_exIsLoad (memory-access class).
  localparam logic [5:0] EX_MEMACC_LB  = 6'h20;
  localparam logic [5:0] EX_MEMACC_LH  = 6'h21;
  localparam logic [5:0] EX_MEMACC_LW  = 6'h23;
  localparam logic [5:0] EX_MEMACC_LBU = 6'h24;
  localparam logic [5:0] EX_MEMACC_LHU = 6'h25;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == EX_MEMACC_LB)  || (op == EX_MEMACC_LH) ||
           (op == EX_MEMACC_LW)  || (op == EX_MEMACC_LBU) ||
           (op == EX_MEMACC_LHU);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags when ID reads a register that the
// load currently in EX has not yet produced. Register 0 never hazards.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_readEnableLeft,
  input  logic       i_readEnableRight,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_exIsLoad,
  input  logic [4:0] i_exDest,
  output logic       o_loadUse
);

  logic [1:0] rd_en;
  logic [4:0] rd_reg [2];
  logic [1:0] rd_hit;

  assign rd_en     = {i_readEnableRight, i_readEnableLeft};
  assign rd_reg[0] = i_rs;
  assign rd_reg[1] = i_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rd_hit[gi] = rd_en[gi] && (rd_reg[gi] == i_exDest);
    end
  endgenerate

  assign o_loadUse = i_exIsLoad && (i_exDest != REG_ZERO) && (|rd_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: prioritised stall/bubble vector, branch
// redirect gating and multiply occupancy FSM. PIPE_CTRL_PERF_EN adds counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_idReadEnableLeft,
  input  logic               i_idReadEnableRight,
  input  logic [4:0]         i_idRs,
  input  logic [4:0]         i_idRt,
  input  logic               i_idTakeBranch,
  input  logic               i_exIsLoad,
  input  logic [4:0]         i_exDest,
  input  logic               i_exIsMult,
  input  logic               i_memBusy,
  output logic [STALL_W-1:0] o_stall,
  output logic [STALL_W-1:0] o_bubble,
  output logic               o_redirect,
  output logic               o_busy,
  output logic [31:0]        o_perfMem,
  output logic [31:0]        o_perfMult,
  output logic [31:0]        o_perfLoadUse
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

  pctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             mult_stall;
  logic             cause_mem, cause_mult, cause_lu;
  logic [STALL_W-1:0] stall_d, bubble_d;

  hazard_detect u_hazard_detect (
    .i_readEnableLeft  (i_idReadEnableLeft),
    .i_readEnableRight (i_idReadEnableRight),
    .i_rs              (i_idRs),
    .i_rt              (i_idRt),
    .i_exIsLoad        (i_exIsLoad),
    .i_exDest          (i_exDest),
    .o_loadUse         (load_use)
  );

  // Multiply FSM: DONE always falls back to IDLE so a still-high i_exIsMult
  // while the MULT retires cannot retrigger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PCTRL_IDLE: begin
        if (i_exIsMult && !i_memBusy) begin
          state_d = PCTRL_MUL;
          cnt_d   = CNT_LOAD;
        end
      end
      PCTRL_MUL: begin
        if (!i_memBusy) begin
          if (cnt_q == '0) begin
            state_d = PCTRL_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      PCTRL_DONE: state_d = PCTRL_IDLE;
      default:    state_d = PCTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PCTRL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mult_stall = ((state_q == PCTRL_IDLE) && i_exIsMult) ||
                      (state_q == PCTRL_MUL);

  // Priority-encoded cause; each cause holds every latch below its bubble.
  always_comb begin
    cause_mem  = 1'b0;
    cause_mult = 1'b0;
    cause_lu   = 1'b0;
    stall_d    = '0;
    bubble_d   = '0;
    if (!rst) begin
      if (i_memBusy) begin
        cause_mem = 1'b1;
        stall_d   = 5'b01111;
        bubble_d  = 5'b10000;
      end else if (mult_stall) begin
        cause_mult = 1'b1;
        stall_d    = 5'b00111;
        bubble_d   = 5'b01000;
      end else if (load_use) begin
        cause_lu = 1'b1;
        stall_d  = 5'b00011;
        bubble_d = 5'b00100;
      end
    end
  end

  assign o_stall    = stall_d;
  assign o_bubble   = bubble_d;
  assign o_redirect = !rst && i_idTakeBranch && !stall_d[STALL_IFID];
  assign o_busy     = !rst && (state_q != PCTRL_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_mult_q, perf_mult_d;
  logic [31:0] perf_lu_q, perf_lu_d;

  always_comb begin
    perf_mem_d  = perf_mem_q  + {31'd0, cause_mem};
    perf_mult_d = perf_mult_q + {31'd0, cause_mult};
    perf_lu_d   = perf_lu_q   + {31'd0, cause_lu};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mem_q  <= '0;
      perf_mult_q <= '0;
      perf_lu_q   <= '0;
    end else begin
      perf_mem_q  <= perf_mem_d;
      perf_mult_q <= perf_mult_d;
      perf_lu_q   <= perf_lu_d;
    end
  end

  assign o_perfMem     = perf_mem_q;
  assign o_perfMult    = perf_mult_q;
  assign o_perfLoadUse = perf_lu_q;
`else
  logic perf_unused;
  assign perf_unused   = cause_mem ^ cause_mult ^ cause_lu;
  assign o_perfMem     = '0;
  assign o_perfMult    = '0;
  assign o_perfLoadUse = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MUL_CYCLES=4): load-use, zero
// register, mult occupancy, mem wait during MUL, branch gating, reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_idReadEnableLeft, i_idReadEnableRight;
  logic [4:0]  i_idRs, i_idRt;
  logic        i_idTakeBranch;
  logic        i_exIsLoad;
  logic [4:0]  i_exDest;
  logic        i_exIsMult;
  logic        i_memBusy;
  logic [4:0]  o_stall, o_bubble;
  logic        o_redirect, o_busy;
  logic [31:0] o_perfMem, o_perfMult, o_perfLoadUse;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_idReadEnableLeft  (i_idReadEnableLeft),
    .i_idReadEnableRight (i_idReadEnableRight),
    .i_idRs              (i_idRs),
    .i_idRt              (i_idRt),
    .i_idTakeBranch      (i_idTakeBranch),
    .i_exIsLoad          (i_exIsLoad),
    .i_exDest            (i_exDest),
    .i_exIsMult          (i_exIsMult),
    .i_memBusy           (i_memBusy),
    .o_stall             (o_stall),
    .o_bubble            (o_bubble),
    .o_redirect          (o_redirect),
    .o_busy              (o_busy),
    .o_perfMem           (o_perfMem),
    .o_perfMult          (o_perfMult),
    .o_perfLoadUse       (o_perfLoadUse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_idReadEnableLeft  = 1'b0;
    i_idReadEnableRight = 1'b0;
    i_idRs              = 5'd0;
    i_idRt              = 5'd0;
    i_idTakeBranch      = 1'b0;
    i_exIsLoad          = 1'b0;
    i_exDest            = 5'd0;
    i_exIsMult          = 1'b0;
    i_memBusy           = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},    {27'd0, o_stall},    32'd0);
    check({tag, ".bubble"},   {27'd0, o_bubble},   32'd0);
    check({tag, ".redirect"}, {31'd0, o_redirect}, 32'd0);
    check({tag, ".busy"},     {31'd0, o_busy},     32'd0);
  endtask

  // Expected per-cycle values for MULT sequences
  logic [4:0] mul_stall_exp [5] = '{5'h07, 5'h07, 5'h07, 5'h07, 5'h00};
  logic [4:0] mul_bub_exp   [5] = '{5'h08, 5'h08, 5'h08, 5'h08, 5'h00};
  logic       mul_busy_exp  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       mw_mem        [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [4:0] mw_stall_exp  [7] = '{5'h07, 5'h07, 5'h0F, 5'h0F, 5'h07, 5'h07, 5'h00};
  logic [4:0] mw_bub_exp    [7] = '{5'h08, 5'h08, 5'h10, 5'h10, 5'h08, 5'h08, 5'h00};

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    // Reset masks every cause
    i_memBusy = 1'b1; i_exIsMult = 1'b1; i_idTakeBranch = 1'b1;
    #1;
    check_all_zero("rst_hold");
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();

`ifdef PIPE_CTRL_PERF_EN
    check("perf_mem_rst", o_perfMem, 32'd0);
    i_memBusy = 1'b1;
    tick();
    tick();
    i_memBusy = 1'b0;
    i_exIsLoad = 1'b1; i_exDest = 5'd9; i_idReadEnableLeft = 1'b1; i_idRs = 5'd9;
    tick();
    clear_inputs();
    tick();
    check("perf_mem",  o_perfMem,     32'd2);
    check("perf_lu",   o_perfLoadUse, 32'd1);
    check("perf_mult", o_perfMult,    32'd0);
`endif

    // Load-use on rs with a taken branch in ID
    i_exIsLoad = 1'b1; i_exDest = 5'd3;
    i_idReadEnableLeft = 1'b1; i_idRs = 5'd3; i_idTakeBranch = 1'b1;
    #1;
    check("lu_rs.stall",    {27'd0, o_stall},    32'h03);
    check("lu_rs.bubble",   {27'd0, o_bubble},   32'h04);
    check("lu_rs.redirect", {31'd0, o_redirect}, 32'd0);
    tick();
    i_exIsLoad = 1'b0; i_exDest = 5'd0;
    #1;
    check("lu_after.stall",    {27'd0, o_stall},    32'h00);
    check("lu_after.redirect", {31'd0, o_redirect}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("br_once.redirect", {31'd0, o_redirect}, 32'd0);

    // Load-use on rt, then same regs with read enable off
    i_exIsLoad = 1'b1; i_exDest = 5'd7; i_idReadEnableRight = 1'b1; i_idRt = 5'd7;
    i_idRs = 5'd7;
    #1;
    check("lu_rt.stall", {27'd0, o_stall}, 32'h03);
    i_idReadEnableRight = 1'b0;
    #1;
    check("lu_noen.stall", {27'd0, o_stall}, 32'h00);
    i_idReadEnableRight = 1'b1; i_idRt = 5'd8;
    #1;
    check("lu_diff.stall", {27'd0, o_stall}, 32'h00);

    // Zero register never hazards
    i_exDest = 5'd0; i_idRs = 5'd0; i_idRt = 5'd0; i_idReadEnableLeft = 1'b1;
    #1;
    check("lu_zero.stall", {27'd0, o_stall}, 32'h00);
    clear_inputs();

    // Memory wait alone, with branch suppressed
    i_memBusy = 1'b1; i_idTakeBranch = 1'b1;
    #1;
    check("mem.stall",    {27'd0, o_stall},    32'h0F);
    check("mem.bubble",   {27'd0, o_bubble},   32'h10);
    check("mem.redirect", {31'd0, o_redirect}, 32'd0);
    tick();
    clear_inputs();
    tick();

    // MULT with memory idle: 4 stall cycles, DONE must not retrigger
    for (int c = 0; c < 5; c++) begin
      i_exIsMult = 1'b1;
      if (c == 1) begin
        i_exIsLoad = 1'b1; i_exDest = 5'd4; i_idReadEnableLeft = 1'b1; i_idRs = 5'd4;
      end else begin
        i_exIsLoad = 1'b0; i_idReadEnableLeft = 1'b0;
      end
      #1;
      check($sformatf("mul%0d.stall", c + 1),  {27'd0, o_stall},  {27'd0, mul_stall_exp[c]});
      check($sformatf("mul%0d.bubble", c + 1), {27'd0, o_bubble}, {27'd0, mul_bub_exp[c]});
      check($sformatf("mul%0d.busy", c + 1),   {31'd0, o_busy},   {31'd0, mul_busy_exp[c]});
      tick();
    end
    clear_inputs();
    #1;
    check("mul_idle.busy",  {31'd0, o_busy},  32'd0);
    check("mul_idle.stall", {27'd0, o_stall}, 32'd0);
    tick();

    // MULT with 2 mem-wait cycles mid-MUL: 6 cycles of occupancy
    for (int c = 0; c < 7; c++) begin
      i_exIsMult = 1'b1;
      i_memBusy  = mw_mem[c];
      #1;
      check($sformatf("mw%0d.stall", c + 1),  {27'd0, o_stall},  {27'd0, mw_stall_exp[c]});
      check($sformatf("mw%0d.bubble", c + 1), {27'd0, o_bubble}, {27'd0, mw_bub_exp[c]});
      tick();
    end
    clear_inputs();
    tick();

    // Reset mid-MUL with counter at 1
    i_exIsMult = 1'b1;
    tick();
    tick();
    #1;
    check("rmul.busy_pre", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rmul_in_rst");
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check_all_zero("rmul_after");
`ifdef PIPE_CTRL_PERF_EN
    check("rmul.perf_mem",  o_perfMem,     32'd0);
    check("rmul.perf_mult", o_perfMult,    32'd0);
    check("rmul.perf_lu",   o_perfLoadUse, 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage toy MIPS core (IF, ID, EX, MEM, WB).
- Detects load-use hazards from the ID stage's register-read requests.
- Holds the pipeline during multi-cycle MULT/MULTU in EX and during memory wait in MEM.
- Gates ID branch redirects so the PC is only updated when the ID stage actually advances.
- Produces one per-latch stall vector consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB.

Parameters:
- MUL_CYCLES, 4, total EX occupancy in cycles of a MULT/MULTU (legal range 2..16).
- CNT_W, 4, width of the multiply cycle counter; must satisfy 2^CNT_W >= MUL_CYCLES.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_idReadEnableLeft  in  1  ID reads rs
- i_idReadEnableRight  in  1  ID reads rt
- i_idRs  in  5  rs field of the instruction in ID
- i_idRt  in  5  rt field of the instruction in ID
- i_idTakeBranch  in  1  ID resolved a taken branch/jump
- i_exIsLoad  in  1  EX holds LB/LBU/LH/LHU/LW
- i_exDest  in  5  EX destination register
- i_exIsMult  in  1  EX holds MULT/MULTU
- i_memBusy  in  1  MEM access not complete this cycle
- o_stall  out  5  hold bits: [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB
- o_bubble  out  5  same indexing; latch loads NOP/zero-dest instead of its input
- o_redirect  out  1  PC takes the ID jump target this cycle
- o_busy  out  1  multiply FSM not IDLE

Behaviour:
- Reset (rst=1 at edge): FSM to IDLE, counter to 0. While rst is high, o_stall=0, o_bubble=0, o_redirect=0, o_busy=0, regardless of inputs.
- Outputs are combinational from registered FSM state plus current inputs. Latency from cause to stall is 0 cycles.
- FSM states are IDLE, MUL, DONE.
  - IDLE -> MUL when i_exIsMult=1 and i_memBusy=0. Counter loads MUL_CYCLES-2.
  - MUL: if i_memBusy=0, counter decrements; when the counter is 0 at the edge -> DONE. If i_memBusy=1, the counter is frozen.
  - DONE -> IDLE unconditionally. In DONE the multiply retires and i_exIsMult may still be high; it must not retrigger.
  - MUL cannot be entered from DONE.
- mult_stall = (state==IDLE and i_exIsMult) or state==MUL. A MULT therefore occupies EX for exactly MUL_CYCLES cycles when memory is idle.
- load_use = i_exIsLoad and i_exDest!=0 and ((i_idReadEnableLeft and i_idRs==i_exDest) or (i_idReadEnableRight and i_idRt==i_exDest)). Register 0 never hazards.
- Priority, highest first:
  - i_memBusy: o_stall=5'b01111, o_bubble=5'b10000.
  - mult_stall: o_stall=5'b00111, o_bubble=5'b01000.
  - load_use: o_stall=5'b00011, o_bubble=5'b00100.
  - otherwise: o_stall=0, o_bubble=0.
- Invariants: o_stall and o_bubble never overlap; the bubble bit is always the lowest-indexed unheld latch above the held ones.
- o_redirect = i_idTakeBranch and not o_stall[1]. A branch in ID during any stall is re-evaluated next cycle with fresh operands. The delay slot is already in IF and is never squashed.
- Simultaneous load_use and mult: the mult stall covers it (ID is already held).
- Reset mid-MUL returns to IDLE immediately; the in-flight multiply is abandoned.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: three 32-bit registers count cycles with the mem, mult and load-use stall causes active, credited to the highest-priority cause only. They are exported on o_perfMem, o_perfMult and o_perfLoadUse (32 bits each), clear on rst, and wrap at 2^32 without saturating.
- Undefined: the same ports exist, tied to zero, with no counter flops.

Decomposition:
- Shared defines header:
  - stall bit indices (STALL_PC..STALL_MEMWB) and the 5-bit width;
  - FSM state encodings (PCTRL_IDLE, PCTRL_MUL, PCTRL_DONE);
  - reuse of REG_ZERO and the existing EX_MEMACC load opcode defines used by EX to form i_exIsLoad.
- Sub-module: hazard_detect, the combinational load-use comparator producing load_use. This is the only sub-module.

Test Plan:
- Load-use: LW to $3 in EX, ID ADD reads rs=$3 (readEnableLeft=1) -> o_stall=00011, o_bubble=00100 for 1 cycle; next cycle with EX=bubble -> o_stall=0.
- Zero register: LW with exDest=0, ID reads $0 -> no stall.
- Mult: MULT in EX, MUL_CYCLES=4, memBusy=0 -> o_stall=00111 for 4 consecutive cycles, o_busy high in cycles 2-4. The fifth cycle with i_exIsMult still high while in DONE -> o_stall=0.
- Mem wait during MUL: i_memBusy=1 for 2 cycles mid-MUL -> o_stall=01111 for those cycles, counter frozen; total MULT occupancy = 4+2 cycles.
- Branch gating: i_idTakeBranch=1 with a load-use hazard -> o_redirect=0; next cycle, hazard gone -> o_redirect=1 for exactly 1 cycle.
- Reset: assert rst in MUL with counter=1 -> next cycle o_busy=0, all outputs 0. With PIPE_CTRL_PERF_EN, the perf counters read 0.
